mem_wb_stage_ext: RTL and testbench
===================================

Name: mem_wb_stage_ext

Overview:
Parametrised memory-access stage plus MEM/WB pipeline register for the pipelined RISC-V core.
- Adds RV32I sub-word loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte enables and sign/zero extension.
- Detects misaligned and illegal accesses.
- Models a configurable-latency data memory that stalls upstream stages via a wait-state FSM.
- Sits between the execute/memory register and the writeback mux; feeds the forwarding unit via rd_w/reg_write_w.

Parameters:
XLEN, 32, datapath width (only 32 supported; byte-lane logic assumes 4 lanes)
DEPTH_WORDS, 256, data memory depth in words; AW = clog2(DEPTH_WORDS)
MEM_LAT, 0, extra wait cycles per memory access (0 = single-cycle, as today)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
valid_m  input  1  M-stage instruction valid (0 = bubble)
reg_write_m  input  1  register write enable
result_src_m  input  2  00 ALU, 01 memory, 10 PC+4
mem_write_m  input  1  store
mem_read_m  input  1  load
funct3_m  input  3  access size/sign (RV32I encoding)
rd_m  input  5  destination register
pc_plus4_m  input  XLEN  PC+4
alu_result_m  input  XLEN  effective address / ALU result
write_data_m  input  XLEN  store data (unaligned, low bytes significant)
stall_m  output  1  hold M stage and all upstream stages
valid_w  output  1  W-stage valid
reg_write_w  output  1  register write enable (gated)
result_src_w  output  2  registered result_src_m
rd_w  output  5  destination register
pc_plus4_w  output  XLEN  registered PC+4
alu_result_w  output  XLEN  registered ALU result
read_data_w  output  XLEN  aligned, extended load data
exc_w  output  1  misaligned/illegal access flag

Behaviour:
- Reset (rst=0, async): all W outputs are 0, stall_m=0, FSM=IDLE. Memory contents are not cleared.
- Address decoding:
  - Word index = alu_result_m[AW+1:2]; byte offset = alu_result_m[1:0].
  - Addresses beyond depth wrap modulo DEPTH_WORDS.
- Access legality:
  - Legal funct3 for loads: 000, 001, 010, 100, 101. For stores: 000, 001, 010.
  - Misaligned: half with off[0]=1, or word with off!=0.
  - Illegal or misaligned access (err): no memory write, reg_write_w=0, exc_w=1, read_data_w=0.
- Stores write at the completion edge.
  - Byte enables: SB 0001<<off; SH 0011<<off; SW 1111.
  - Data: write_data_m byte 0 (SB) or bytes 1:0 (SH) is replicated to the selected lanes.
- Loads read combinationally from the memory word.
  - Lane select: byte/half extracted at off, shifted to bit 0.
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Mem op = valid_m & (mem_read_m | mem_write_m) & ~err. Err accesses never wait.
- FSM when MEM_LAT=0: no waiting. W register captures every cycle; latency M->W is 1 cycle; stall_m=0 always.
- FSM when MEM_LAT>0, states IDLE and WAIT:
  - IDLE + mem op: stall_m=1, cnt loads MEM_LAT-1, go to WAIT. W captures a bubble (valid_w=0, reg_write_w=0, exc_w=0; other fields don't-care but hold their previous values).
  - WAIT, cnt!=0: stall_m=1, cnt decrements, W captures a bubble.
  - WAIT, cnt==0: stall_m=0, the access completes (write performed / read data captured), W captures the instruction, go to IDLE.
  - Net latency: MEM_LAT+1 cycles M->W. Upstream inputs must hold steady while stall_m=1 (upstream holds them stable; this is not checked here).
  - Non-memory instructions in IDLE pass in 1 cycle.
  - Back-to-back memory ops each incur the full wait.
- Bubble handling: valid_m=0 forces valid_w=0, reg_write_w=0, exc_w=0. No memory write.
- reg_write_w = reg_write_m & valid_m & ~err, registered.
- Reset mid-WAIT: FSM returns to IDLE, the pending store is discarded, stall_m drops immediately.

Test Plan:
1. SW 0xDEADBEEF at 0x10, then LW 0x10 (MEM_LAT=0) -> read_data_w=0xDEADBEEF one cycle after the load; reg_write_w=1.
2. SB 0x80 at 0x13, then LB 0x13 / LBU 0x13 -> 0xFFFFFF80 / 0x00000080; word 0x10 = 0x80ADBEEF.
3. LH 0x11 and SW 0x12 -> exc_w=1, reg_write_w=0, memory word unchanged; LW 0x10 still returns the prior value.
4. MEM_LAT=2, LW issued -> stall_m high 2 cycles, two bubbles on W (valid_w=0), data on W at cycle 3; following ADD passes in 1 cycle.
5. MEM_LAT=2, SW 0x1234 at 0x20, rst pulsed low during the first WAIT cycle -> all W outputs 0, stall_m=0, LW 0x20 returns the old contents.
6. valid_m=0 with mem_write_m=1, address 0x30 -> no write (LW 0x30 unchanged), valid_w=0, reg_write_w=0.

Source files
------------

// File: rtl/mem_wb_stage_ext.sv
// Memory-access stage and MEM/WB pipeline register: RV32I sub-word loads/stores,
// misaligned/illegal access detection, and an optional wait-state model for slow memory.
//
// state  | meaning
// S_IDLE | no access in flight; non-memory ops and MEM_LAT=0 accesses complete here
// S_WAIT | memory access in flight; r_cnt counts remaining wait cycles down to 0
module mem_wb_stage_ext #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LAT     = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_m,
    input  logic            reg_write_m,
    input  logic [1:0]      result_src_m,
    input  logic            mem_write_m,
    input  logic            mem_read_m,
    input  logic [2:0]      funct3_m,
    input  logic [4:0]      rd_m,
    input  logic [XLEN-1:0] pc_plus4_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] write_data_m,
    output logic            stall_m,
    output logic            valid_w,
    output logic            reg_write_w,
    output logic [1:0]      result_src_w,
    output logic [4:0]      rd_w,
    output logic [XLEN-1:0] pc_plus4_w,
    output logic [XLEN-1:0] alu_result_w,
    output logic [XLEN-1:0] read_data_w,
    output logic            exc_w
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = (MEM_LAT > 0) ? CW'(MEM_LAT - 1) : '0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    logic            r_valid, r_reg_write, r_exc;
    logic [1:0]      r_result_src;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_pc_plus4, r_alu_result, r_read_data;

    logic [AW-1:0]   w_idx;
    logic [1:0]      w_off;
    logic            w_is_byte, w_is_half, w_is_word;
    logic            w_ld_legal, w_st_legal, w_misal, w_err, w_mem_op;
    logic            w_complete, w_stall, w_mem_we;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata, w_rword, w_shifted, w_ext;
    logic            w_unused;

    assign w_idx     = alu_result_m[AW+1:2];
    assign w_off     = alu_result_m[1:0];
    assign w_unused  = ^alu_result_m[XLEN-1:AW+2];
    assign w_is_byte = (funct3_m[1:0] == 2'b00);
    assign w_is_half = (funct3_m[1:0] == 2'b01);
    assign w_is_word = (funct3_m[1:0] == 2'b10);

    assign w_ld_legal = w_is_byte | w_is_half | (w_is_word & ~funct3_m[2]);
    assign w_st_legal = ~funct3_m[2] & (w_is_byte | w_is_half | w_is_word);
    assign w_misal    = (w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00));
    assign w_err      = valid_m & ((mem_read_m  & (~w_ld_legal | w_misal)) |
                                   (mem_write_m & (~w_st_legal | w_misal)));
    assign w_mem_op   = valid_m & (mem_read_m | mem_write_m) & ~w_err;

    // Store data is replicated across lanes; byte enables pick the live ones.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = write_data_m;
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{write_data_m[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{write_data_m[15:0]}};
        end
    end

    assign w_rword   = r_mem[w_idx];
    assign w_shifted = w_rword >> {w_off, 3'b000};

    always_comb begin
        w_ext = w_rword;
        case (funct3_m)
            3'b000:  w_ext = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_ext = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ext = {{(XLEN-8){1'b0}},           w_shifted[7:0]};
            3'b101:  w_ext = {{(XLEN-16){1'b0}},          w_shifted[15:0]};
            default: w_ext = w_rword;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b1;
        w_stall     = 1'b0;
        if (MEM_LAT > 0) begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        w_stall     = 1'b1;
                        w_complete  = 1'b0;
                        w_cnt_nxt   = CNT_INIT;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        w_stall    = 1'b1;
                        w_complete = 1'b0;
                        w_cnt_nxt  = r_cnt - CW'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Reset gates the stall combinationally so upstream is released immediately.
    assign stall_m  = rst & w_stall;
    assign w_mem_we = rst & w_complete & w_mem_op & mem_write_m;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_exc        <= 1'b0;
            r_result_src <= '0;
            r_rd         <= '0;
            r_pc_plus4   <= '0;
            r_alu_result <= '0;
            r_read_data  <= '0;
        end else if (w_complete) begin
            r_valid      <= valid_m;
            r_reg_write  <= reg_write_m & valid_m & ~w_err;
            r_exc        <= w_err;
            r_result_src <= result_src_m;
            r_rd         <= rd_m;
            r_pc_plus4   <= pc_plus4_m;
            r_alu_result <= alu_result_m;
            r_read_data  <= (valid_m & mem_read_m & ~w_err) ? w_ext : '0;
        end else begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_exc       <= 1'b0;
        end
    end

    assign valid_w      = r_valid;
    assign reg_write_w  = r_reg_write;
    assign exc_w        = r_exc;
    assign result_src_w = r_result_src;
    assign rd_w         = r_rd;
    assign pc_plus4_w   = r_pc_plus4;
    assign alu_result_w = r_alu_result;
    assign read_data_w  = r_read_data;

endmodule

// File: tb/tb_mem_wb_stage_ext.sv
// Directed bench for mem_wb_stage_ext: a single-cycle instance and a MEM_LAT=2 instance
// share stimulus; each phase checks only the instance under test.
module tb_mem_wb_stage_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_m, reg_write_m, mem_write_m, mem_read_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [4:0]  rd_m;
    logic [31:0] pc_plus4_m, alu_result_m, write_data_m;

    logic        s0_stall, s0_valid, s0_rw, s0_exc;
    logic [1:0]  s0_rsrc;
    logic [4:0]  s0_rd;
    logic [31:0] s0_pc, s0_alu, s0_rdata;
    logic        s2_stall, s2_valid, s2_rw, s2_exc;
    logic [1:0]  s2_rsrc;
    logic [4:0]  s2_rd;
    logic [31:0] s2_pc, s2_alu, s2_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_wb_stage_ext #(.XLEN(32), .DEPTH_WORDS(256), .MEM_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .valid_m(valid_m), .reg_write_m(reg_write_m),
        .result_src_m(result_src_m), .mem_write_m(mem_write_m), .mem_read_m(mem_read_m),
        .funct3_m(funct3_m), .rd_m(rd_m), .pc_plus4_m(pc_plus4_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .stall_m(s0_stall), .valid_w(s0_valid), .reg_write_w(s0_rw),
        .result_src_w(s0_rsrc), .rd_w(s0_rd), .pc_plus4_w(s0_pc),
        .alu_result_w(s0_alu), .read_data_w(s0_rdata), .exc_w(s0_exc)
    );

    mem_wb_stage_ext #(.XLEN(32), .DEPTH_WORDS(256), .MEM_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .valid_m(valid_m), .reg_write_m(reg_write_m),
        .result_src_m(result_src_m), .mem_write_m(mem_write_m), .mem_read_m(mem_read_m),
        .funct3_m(funct3_m), .rd_m(rd_m), .pc_plus4_m(pc_plus4_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .stall_m(s2_stall), .valid_w(s2_valid), .reg_write_w(s2_rw),
        .result_src_w(s2_rsrc), .rd_w(s2_rd), .pc_plus4_w(s2_pc),
        .alu_result_w(s2_alu), .read_data_w(s2_rdata), .exc_w(s2_exc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rw, input logic [1:0] rs,
                          input logic mw, input logic mr, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] wd);
        valid_m      = v;
        reg_write_m  = rw;
        result_src_m = rs;
        mem_write_m  = mw;
        mem_read_m   = mr;
        funct3_m     = f3;
        rd_m         = rd;
        alu_result_m = addr;
        write_data_m = wd;
        pc_plus4_m   = 32'h8000_0000 | addr;
        #1;
    endtask

    task automatic idle_op();
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    endtask

    // Single-cycle instance: drive one op, clock it into W.
    task automatic op0(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic mr, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] wd);
        set_op(1'b1, rw, rs, mw, mr, f3, rd, addr, wd);
        tick();
    endtask

    // Latency-2 instance: hold the op through both wait cycles.
    task automatic op2(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic mr, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] wd);
        set_op(1'b1, rw, rs, mw, mr, f3, rd, addr, wd);
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        idle_op();
        #1;
        chk("rst_stall0", {31'b0, s0_stall}, 32'h0);
        chk("rst_valid0", {31'b0, s0_valid}, 32'h0);
        chk("rst_rdata0", s0_rdata, 32'h0);
        tick();
        tick();
        rst = 1'b1;

        // Word store then load, single cycle
        op0(1'b0, 2'b00, 1'b1, 1'b0, 3'b010, 5'd0, 32'h10, 32'hDEAD_BEEF);
        chk("sw_valid", {31'b0, s0_valid}, 32'h1);
        chk("sw_rw", {31'b0, s0_rw}, 32'h0);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd5, 32'h10, 32'h0);
        chk("lw_data", s0_rdata, 32'hDEAD_BEEF);
        chk("lw_rw", {31'b0, s0_rw}, 32'h1);
        chk("lw_rd", {27'b0, s0_rd}, 32'd5);
        chk("lw_rsrc", {30'b0, s0_rsrc}, 32'd1);

        // Byte store and sign/zero-extending sub-word loads
        op0(1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 5'd0, 32'h13, 32'h1234_5680);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 5'd6, 32'h13, 32'h0);
        chk("lb_13", s0_rdata, 32'hFFFF_FF80);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b100, 5'd6, 32'h13, 32'h0);
        chk("lbu_13", s0_rdata, 32'h0000_0080);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd6, 32'h10, 32'h0);
        chk("lw_after_sb", s0_rdata, 32'h80AD_BEEF);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b001, 5'd6, 32'h12, 32'h0);
        chk("lh_12", s0_rdata, 32'hFFFF_80AD);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b101, 5'd6, 32'h12, 32'h0);
        chk("lhu_12", s0_rdata, 32'h0000_80AD);
        op0(1'b0, 2'b00, 1'b1, 1'b0, 3'b001, 5'd0, 32'h10, 32'hFFFF_1234);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd6, 32'h10, 32'h0);
        chk("lw_after_sh", s0_rdata, 32'h80AD_1234);

        // Misaligned and illegal accesses
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b001, 5'd8, 32'h11, 32'h0);
        chk("lh_mis_exc", {31'b0, s0_exc}, 32'h1);
        chk("lh_mis_rw", {31'b0, s0_rw}, 32'h0);
        chk("lh_mis_data", s0_rdata, 32'h0);
        op0(1'b0, 2'b00, 1'b1, 1'b0, 3'b010, 5'd0, 32'h12, 32'h5555_5555);
        chk("sw_mis_exc", {31'b0, s0_exc}, 32'h1);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b011, 5'd8, 32'h10, 32'h0);
        chk("ld_f3_011_exc", {31'b0, s0_exc}, 32'h1);
        op0(1'b0, 2'b00, 1'b1, 1'b0, 3'b100, 5'd0, 32'h10, 32'h6666_6666);
        chk("st_f3_100_exc", {31'b0, s0_exc}, 32'h1);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd6, 32'h10, 32'h0);
        chk("lw_after_err", s0_rdata, 32'h80AD_1234);
        chk("lw_after_err_exc", {31'b0, s0_exc}, 32'h0);

        // Bubble store is dropped; address wraps modulo depth
        op0(1'b0, 2'b00, 1'b1, 1'b0, 3'b010, 5'd0, 32'h30, 32'h1111_1111);
        set_op(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 3'b010, 5'd4, 32'h30, 32'h2222_2222);
        tick();
        chk("bub_valid", {31'b0, s0_valid}, 32'h0);
        chk("bub_rw", {31'b0, s0_rw}, 32'h0);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd6, 32'h30, 32'h0);
        chk("lw_after_bub", s0_rdata, 32'h1111_1111);
        op0(1'b0, 2'b00, 1'b1, 1'b0, 3'b010, 5'd0, 32'h430, 32'h3333_3333);
        op0(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd6, 32'h30, 32'h0);
        chk("lw_wrap", s0_rdata, 32'h3333_3333);

        // Non-memory op with PC+4 writeback
        op0(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 5'd3, 32'h44, 32'h0);
        chk("jal_rsrc", {30'b0, s0_rsrc}, 32'd2);
        chk("jal_pc", s0_pc, 32'h8000_0044);
        chk("jal_stall", {31'b0, s0_stall}, 32'h0);

        // Latency-2 instance: fresh reset, then preload 0x20
        idle_op();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        op2(1'b0, 2'b00, 1'b1, 1'b0, 3'b010, 5'd0, 32'h20, 32'hCAFE_F00D);

        set_op(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd7, 32'h20, 32'h0);
        chk("l2_stall_c0", {31'b0, s2_stall}, 32'h1);
        tick();
        chk("l2_bub1_valid", {31'b0, s2_valid}, 32'h0);
        chk("l2_stall_c1", {31'b0, s2_stall}, 32'h1);
        tick();
        chk("l2_bub2_valid", {31'b0, s2_valid}, 32'h0);
        chk("l2_stall_c2", {31'b0, s2_stall}, 32'h0);
        tick();
        chk("l2_lw_valid", {31'b0, s2_valid}, 32'h1);
        chk("l2_lw_data", s2_rdata, 32'hCAFE_F00D);
        chk("l2_lw_rw", {31'b0, s2_rw}, 32'h1);
        set_op(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 5'd9, 32'h55, 32'h0);
        chk("l2_add_stall", {31'b0, s2_stall}, 32'h0);
        tick();
        chk("l2_add_valid", {31'b0, s2_valid}, 32'h1);
        chk("l2_add_alu", s2_alu, 32'h0000_0055);
        chk("l2_add_rd", {27'b0, s2_rd}, 32'd9);

        // Reset during the first wait cycle of a store
        set_op(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'b010, 5'd0, 32'h20, 32'h0000_1234);
        tick();
        chk("l2_sw_stall_wait", {31'b0, s2_stall}, 32'h1);
        rst = 1'b0;
        #1;
        chk("l2_rst_stall", {31'b0, s2_stall}, 32'h0);
        chk("l2_rst_alu", s2_alu, 32'h0);
        chk("l2_rst_pc", s2_pc, 32'h0);
        chk("l2_rst_rd", {27'b0, s2_rd}, 32'h0);
        chk("l2_rst_valid", {31'b0, s2_valid}, 32'h0);
        tick();
        tick();
        idle_op();
        rst = 1'b1;
        tick();
        op2(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd7, 32'h20, 32'h0);
        chk("l2_lw_after_rst", s2_rdata, 32'hCAFE_F00D);

        idle_op();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
